// File: rtl/rs_pkg.sv
// Shared types and defaults for the ALU reservation station.
package rs_pkg;

   localparam int unsigned RS_ROB_ID_W = 5;
   localparam int unsigned RS_XLEN     = 32;

   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;

   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [6:0] funct7;
   } rs_op_t;

   // Width-independent status of an entry; operand values and tags are held beside it.
   typedef struct packed {
      logic   busy;
      logic   qj_valid;
      logic   qk_valid;
      rs_op_t op;
   } rs_entry_t;

endpackage

// File: rtl/rs_pick_lowest.sv
// Find-first-set from bit 0: reports whether any request is set and the lowest set index.
module rs_pick_lowest #(
   parameter int unsigned N = 8,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            found = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/rs_station_n.sv
// Reservation station: DEPTH operand-wait entries with CDB wake-up, feeding a registered
// valid/ready execute port from the lowest-index operand-complete entry.
module rs_station_n
   import rs_pkg::*;
#(
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned ROB_ID_W = RS_ROB_ID_W,
   parameter int unsigned XLEN     = RS_XLEN,
   parameter int unsigned NUM_CDB  = 2,
   localparam int unsigned IDX_W   = $clog2(DEPTH),
   localparam int unsigned OCC_W   = $clog2(DEPTH + 1)
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        rdy_in,
   input  logic                        flush_pipeline,
   input  logic                        issue_valid,
   output logic                        issue_ready,
   input  logic [6:0]                  issue_opcode,
   input  logic [2:0]                  issue_funct3,
   input  logic [6:0]                  issue_funct7,
   input  logic [ROB_ID_W-1:0]         issue_rob_id,
   input  logic [XLEN-1:0]             issue_vj,
   input  logic [XLEN-1:0]             issue_vk,
   input  logic                        issue_qj_valid,
   input  logic                        issue_qk_valid,
   input  logic [ROB_ID_W-1:0]         issue_qj,
   input  logic [ROB_ID_W-1:0]         issue_qk,
   input  logic [NUM_CDB-1:0]          cdb_valid,
   input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id,
   input  logic [NUM_CDB*XLEN-1:0]     cdb_value,
   output logic                        exec_valid,
   input  logic                        exec_ready,
   output logic [6:0]                  exec_opcode,
   output logic [2:0]                  exec_funct3,
   output logic [6:0]                  exec_funct7,
   output logic [ROB_ID_W-1:0]         exec_rob_id,
   output logic [XLEN-1:0]             exec_vj,
   output logic [XLEN-1:0]             exec_vk,
   output logic [OCC_W-1:0]            occupancy
);

   rs_entry_t           ent_q [DEPTH];
   rs_entry_t           ent_d [DEPTH];
   logic [ROB_ID_W-1:0] rob_q [DEPTH];
   logic [ROB_ID_W-1:0] rob_d [DEPTH];
   logic [ROB_ID_W-1:0] qj_q  [DEPTH];
   logic [ROB_ID_W-1:0] qj_d  [DEPTH];
   logic [ROB_ID_W-1:0] qk_q  [DEPTH];
   logic [ROB_ID_W-1:0] qk_d  [DEPTH];
   logic [XLEN-1:0]     vj_q  [DEPTH];
   logic [XLEN-1:0]     vj_d  [DEPTH];
   logic [XLEN-1:0]     vk_q  [DEPTH];
   logic [XLEN-1:0]     vk_d  [DEPTH];

   logic                ex_valid_d;
   rs_op_t              ex_op_d;
   logic [ROB_ID_W-1:0] ex_rob_d;
   logic [XLEN-1:0]     ex_vj_d;
   logic [XLEN-1:0]     ex_vk_d;

   logic [DEPTH-1:0] free_vec;
   logic [DEPTH-1:0] rdy_vec;
   logic             free_found;
   logic             rdy_found;
   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] rdy_idx;
   logic [XLEN:0]    lk_j;
   logic [XLEN:0]    lk_k;

   // Returns {hit, value}; the lowest-numbered matching channel wins.
   function automatic logic [XLEN:0] cdb_lookup(input logic [ROB_ID_W-1:0]         tag,
                                                input logic [NUM_CDB-1:0]          cv,
                                                input logic [NUM_CDB*ROB_ID_W-1:0] ct,
                                                input logic [NUM_CDB*XLEN-1:0]     cval);
      logic [XLEN:0] r;
      r = '0;
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
         if (cv[c] && ct[c*ROB_ID_W +: ROB_ID_W] == tag) r = {1'b1, cval[c*XLEN +: XLEN]};
      end
      return r;
   endfunction

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         free_vec[i] = !ent_q[i].busy;
         rdy_vec[i]  = ent_q[i].busy && !ent_q[i].qj_valid && !ent_q[i].qk_valid;
         occupancy   = occupancy + OCC_W'(ent_q[i].busy);
      end
   end

   rs_pick_lowest #(.N(DEPTH)) u_pick_free (.req(free_vec), .found(free_found), .idx(free_idx));
   rs_pick_lowest #(.N(DEPTH)) u_pick_rdy  (.req(rdy_vec),  .found(rdy_found),  .idx(rdy_idx));

   // Registered state only: a slot freed by this edge's dispatch is not offered.
   assign issue_ready = free_found;

   always_comb begin
      ent_d      = ent_q;
      rob_d      = rob_q;
      qj_d       = qj_q;
      qk_d       = qk_q;
      vj_d       = vj_q;
      vk_d       = vk_q;
      ex_valid_d = exec_valid;
      ex_op_d    = '{opcode: exec_opcode, funct3: exec_funct3, funct7: exec_funct7};
      ex_rob_d   = exec_rob_id;
      ex_vj_d    = exec_vj;
      ex_vk_d    = exec_vk;
      lk_j       = '0;
      lk_k       = '0;

      for (int i = 0; i < DEPTH; i++) begin
         lk_j = cdb_lookup(qj_q[i], cdb_valid, cdb_rob_id, cdb_value);
         lk_k = cdb_lookup(qk_q[i], cdb_valid, cdb_rob_id, cdb_value);
         if (ent_q[i].busy && ent_q[i].qj_valid && lk_j[XLEN]) begin
            ent_d[i].qj_valid = 1'b0;
            vj_d[i]           = lk_j[XLEN-1:0];
         end
         if (ent_q[i].busy && ent_q[i].qk_valid && lk_k[XLEN]) begin
            ent_d[i].qk_valid = 1'b0;
            vk_d[i]           = lk_k[XLEN-1:0];
         end
      end

      if (!exec_valid || exec_ready) begin
         ex_valid_d = rdy_found;
         if (rdy_found) begin
            ent_d[rdy_idx].busy = 1'b0;
            ex_op_d             = ent_q[rdy_idx].op;
            ex_rob_d            = rob_q[rdy_idx];
            ex_vj_d             = vj_q[rdy_idx];
            ex_vk_d             = vk_q[rdy_idx];
         end
      end

      if (issue_valid && free_found) begin
         lk_j = cdb_lookup(issue_qj, cdb_valid, cdb_rob_id, cdb_value);
         lk_k = cdb_lookup(issue_qk, cdb_valid, cdb_rob_id, cdb_value);
         ent_d[free_idx] = '{busy:     1'b1,
                             qj_valid: issue_qj_valid && !lk_j[XLEN],
                             qk_valid: issue_qk_valid && !lk_k[XLEN],
                             op:       '{opcode: issue_opcode, funct3: issue_funct3,
                                         funct7: issue_funct7}};
         rob_d[free_idx] = issue_rob_id;
         qj_d[free_idx]  = issue_qj;
         qk_d[free_idx]  = issue_qk;
         vj_d[free_idx]  = (issue_qj_valid && lk_j[XLEN]) ? lk_j[XLEN-1:0] : issue_vj;
         vk_d[free_idx]  = (issue_qk_valid && lk_k[XLEN]) ? lk_k[XLEN-1:0] : issue_vk;
      end

      if (flush_pipeline) begin
         for (int i = 0; i < DEPTH; i++) ent_d[i].busy = 1'b0;
         ex_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= '0;
            rob_q[i] <= '0;
            qj_q[i]  <= '0;
            qk_q[i]  <= '0;
            vj_q[i]  <= '0;
            vk_q[i]  <= '0;
         end
         exec_valid  <= 1'b0;
         exec_opcode <= '0;
         exec_funct3 <= '0;
         exec_funct7 <= '0;
         exec_rob_id <= '0;
         exec_vj     <= '0;
         exec_vk     <= '0;
      end else if (rdy_in) begin
         ent_q       <= ent_d;
         rob_q       <= rob_d;
         qj_q        <= qj_d;
         qk_q        <= qk_d;
         vj_q        <= vj_d;
         vk_q        <= vk_d;
         exec_valid  <= ex_valid_d;
         exec_opcode <= ex_op_d.opcode;
         exec_funct3 <= ex_op_d.funct3;
         exec_funct7 <= ex_op_d.funct7;
         exec_rob_id <= ex_rob_d;
         exec_vj     <= ex_vj_d;
         exec_vk     <= ex_vk_d;
      end
   end

endmodule

// File: tb/tb_rs_station_n.sv
// Bench for rs_station_n: slot-level reference model feeding a dispatch scoreboard,
// directed scenarios followed by randomized traffic.
module tb_rs_station_n;
   import rs_pkg::*;

   localparam int DEPTH = 8;
   localparam int RW    = 5;
   localparam int XL    = 32;
   localparam int NC    = 2;
   localparam int OW    = $clog2(DEPTH + 1);

   logic             clk_in = 1'b0;
   logic             rst_in = 1'b0;
   logic             rdy_in = 1'b1;
   logic             flush_pipeline = 1'b0;
   logic             issue_valid = 1'b0;
   logic             issue_ready;
   logic [6:0]       issue_opcode = '0;
   logic [2:0]       issue_funct3 = '0;
   logic [6:0]       issue_funct7 = '0;
   logic [RW-1:0]    issue_rob_id = '0;
   logic [XL-1:0]    issue_vj = '0;
   logic [XL-1:0]    issue_vk = '0;
   logic             issue_qj_valid = 1'b0;
   logic             issue_qk_valid = 1'b0;
   logic [RW-1:0]    issue_qj = '0;
   logic [RW-1:0]    issue_qk = '0;
   logic [NC-1:0]    cdb_valid = '0;
   logic [NC*RW-1:0] cdb_rob_id = '0;
   logic [NC*XL-1:0] cdb_value = '0;
   logic             exec_valid;
   logic             exec_ready = 1'b1;
   logic [6:0]       exec_opcode;
   logic [2:0]       exec_funct3;
   logic [6:0]       exec_funct7;
   logic [RW-1:0]    exec_rob_id;
   logic [XL-1:0]    exec_vj;
   logic [XL-1:0]    exec_vk;
   logic [OW-1:0]    occupancy;

   always #5 clk_in = ~clk_in;

   rs_station_n #(.DEPTH(DEPTH), .ROB_ID_W(RW), .XLEN(XL), .NUM_CDB(NC)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_pipeline(flush_pipeline),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_opcode(issue_opcode),
      .issue_funct3(issue_funct3), .issue_funct7(issue_funct7), .issue_rob_id(issue_rob_id),
      .issue_vj(issue_vj), .issue_vk(issue_vk), .issue_qj_valid(issue_qj_valid),
      .issue_qk_valid(issue_qk_valid), .issue_qj(issue_qj), .issue_qk(issue_qk),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
      .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_opcode(exec_opcode),
      .exec_funct3(exec_funct3), .exec_funct7(exec_funct7), .exec_rob_id(exec_rob_id),
      .exec_vj(exec_vj), .exec_vk(exec_vk), .occupancy(occupancy)
   );

   typedef struct {
      bit          busy;
      bit [6:0]    op;
      bit [2:0]    f3;
      bit [6:0]    f7;
      bit [RW-1:0] rob;
      bit [XL-1:0] vj;
      bit [XL-1:0] vk;
      bit          pj;
      bit          pk;
      bit [RW-1:0] qj;
      bit [RW-1:0] qk;
   } m_ent_t;

   m_ent_t m [DEPTH];
   bit     m_out;
   m_ent_t exp_q [$];
   int     n_chk = 0;
   int     n_pass = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
   endtask

   function automatic int m_count();
      int n = 0;
      foreach (m[i]) if (m[i].busy) n++;
      return n;
   endfunction

   function automatic bit cdb_lookup(input bit [RW-1:0] tag, output bit [XL-1:0] v);
      v = '0;
      for (int c = 0; c < NC; c++) begin
         if (cdb_valid[c] && cdb_rob_id[c*RW +: RW] == tag) begin
            v = cdb_value[c*XL +: XL];
            return 1'b1;
         end
      end
      return 1'b0;
   endfunction

   task automatic model_reset();
      foreach (m[i]) m[i].busy = 1'b0;
      m_out = 1'b0;
      exp_q.delete();
   endtask

   // One clock edge of the station as described behaviourally; uses pre-edge state throughout.
   task automatic model_step();
      int          sel = -1;
      int          fr = -1;
      bit [XL-1:0] v;
      m_ent_t      e;
      if (!rdy_in) return;
      if (flush_pipeline) begin
         model_reset();
         return;
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (m[i].busy && !m[i].pj && !m[i].pk) sel = i;
         if (!m[i].busy) fr = i;
      end
      if (!m_out || exec_ready) begin
         if (m_out) void'(exp_q.pop_front());
         m_out = (sel >= 0);
         if (sel >= 0) begin
            exp_q.push_back(m[sel]);
            m[sel].busy = 1'b0;
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (m[i].busy && m[i].pj) if (cdb_lookup(m[i].qj, v)) begin m[i].vj = v; m[i].pj = 0; end
         if (m[i].busy && m[i].pk) if (cdb_lookup(m[i].qk, v)) begin m[i].vk = v; m[i].pk = 0; end
      end
      if (issue_valid && fr >= 0) begin
         e.busy = 1'b1;
         e.op = issue_opcode; e.f3 = issue_funct3; e.f7 = issue_funct7; e.rob = issue_rob_id;
         e.pj = issue_qj_valid; e.qj = issue_qj; e.vj = issue_vj;
         e.pk = issue_qk_valid; e.qk = issue_qk; e.vk = issue_vk;
         if (e.pj) if (cdb_lookup(e.qj, v)) begin e.vj = v; e.pj = 0; end
         if (e.pk) if (cdb_lookup(e.qk, v)) begin e.vk = v; e.pk = 0; end
         m[fr] = e;
      end
   endtask

   // Monitor: compares DUT state and the presented instruction against the scoreboard.
   always @(negedge clk_in) begin
      if (!rst_in) begin
         chk("occupancy", occupancy, m_count());
         chk("issue_ready", issue_ready, m_count() < DEPTH);
         chk("exec_valid", exec_valid, m_out);
         if (m_out && exp_q.size() > 0) begin
            chk("exec_opcode", exec_opcode, exp_q[0].op);
            chk("exec_funct3", exec_funct3, exp_q[0].f3);
            chk("exec_funct7", exec_funct7, exp_q[0].f7);
            chk("exec_rob_id", exec_rob_id, exp_q[0].rob);
            chk("exec_vj", exec_vj, exp_q[0].vj);
            chk("exec_vk", exec_vk, exp_q[0].vk);
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      model_step();
      #1;
   endtask

   task automatic idle();
      rdy_in = 1'b1; flush_pipeline = 1'b0; issue_valid = 1'b0; cdb_valid = '0;
   endtask

   task automatic set_issue(input logic [6:0] op, input logic [RW-1:0] rob,
                            input logic [XL-1:0] vj, input logic [XL-1:0] vk,
                            input logic pj, input logic [RW-1:0] qj,
                            input logic pk, input logic [RW-1:0] qk);
      issue_valid = 1'b1; issue_opcode = op; issue_funct3 = 3'd0; issue_funct7 = 7'd0;
      issue_rob_id = rob; issue_vj = vj; issue_vk = vk;
      issue_qj_valid = pj; issue_qj = qj; issue_qk_valid = pk; issue_qk = qk;
   endtask

   task automatic set_cdb(input int ch, input logic [RW-1:0] tag, input logic [XL-1:0] val);
      cdb_valid[ch] = 1'b1;
      cdb_rob_id[ch*RW +: RW] = tag;
      cdb_value[ch*XL +: XL] = val;
   endtask

   task automatic rand_inputs();
      logic [6:0] ops [4];
      ops = '{OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC};
      rdy_in = ($urandom_range(0, 9) != 0);
      flush_pipeline = ($urandom_range(0, 49) == 0);
      issue_valid = ($urandom_range(0, 9) < 6);
      issue_opcode = ops[$urandom_range(0, 3)];
      issue_funct3 = 3'($urandom);
      issue_funct7 = 7'($urandom);
      issue_rob_id = RW'($urandom);
      issue_vj = $urandom;
      issue_vk = $urandom;
      issue_qj_valid = ($urandom_range(0, 9) < 4);
      issue_qk_valid = ($urandom_range(0, 9) < 4);
      issue_qj = RW'($urandom_range(0, 7));
      issue_qk = RW'($urandom_range(0, 7));
      for (int c = 0; c < NC; c++) begin
         cdb_valid[c] = ($urandom_range(0, 9) < 3);
         cdb_rob_id[c*RW +: RW] = RW'($urandom_range(0, 7));
         cdb_value[c*XL +: XL] = $urandom;
      end
      exec_ready = ($urandom_range(0, 9) < 7);
   endtask

   initial begin
      model_reset();
      #1 rst_in = 1'b1;
      #2;
      chk("rst_occupancy", occupancy, 0);
      chk("rst_issue_ready", issue_ready, 1);
      chk("rst_exec_valid", exec_valid, 0);
      chk("rst_exec_rob_id", exec_rob_id, 0);
      chk("rst_exec_vj", exec_vj, 0);
      chk("rst_exec_opcode", exec_opcode, 0);
      @(negedge clk_in);
      #2 rst_in = 1'b0;

      // Ready-operand issue: two edges to the execute port.
      exec_ready = 1'b1;
      set_issue(OPC_OP, 5'd4, 32'd5, 32'd7, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
      chk("lat_e0_valid", exec_valid, 0);
      idle();
      tick();
      chk("lat_e1_valid", exec_valid, 1);
      chk("lat_rob", exec_rob_id, 4);
      chk("lat_vj", exec_vj, 5);
      chk("lat_vk", exec_vk, 7);
      chk("lat_opcode", exec_opcode, 7'h33);

      // CDB wake-up on channel 1, then same-cycle bypass.
      set_issue(OPC_OP, 5'd9, 32'd0, 32'd8, 1'b1, 5'd3, 1'b0, 5'd0);
      tick();
      idle();
      tick();
      tick();
      set_cdb(0, 5'd5, 32'h55);
      set_cdb(1, 5'd3, 32'hDEAD);
      tick();
      chk("wake_e_valid", exec_valid, 0);
      idle();
      tick();
      chk("wake_valid", exec_valid, 1);
      chk("wake_vj", exec_vj, 32'hDEAD);
      chk("wake_rob", exec_rob_id, 9);
      set_issue(OPC_OP, 5'd12, 32'd0, 32'd1, 1'b1, 5'd3, 1'b0, 5'd0);
      set_cdb(1, 5'd3, 32'hBEEF);
      tick();
      idle();
      tick();
      chk("bypass_vj", exec_vj, 32'hBEEF);
      chk("bypass_rob", exec_rob_id, 12);

      // Both channels match: channel 0 wins.
      set_issue(OPC_OP, 5'd13, 32'd2, 32'd0, 1'b0, 5'd0, 1'b1, 5'd6);
      tick();
      idle();
      set_cdb(0, 5'd6, 32'h1111);
      set_cdb(1, 5'd6, 32'h2222);
      tick();
      idle();
      tick();
      chk("lowch_vk", exec_vk, 32'h1111);

      // Fill all entries with pending operands; the ninth issue must wait.
      for (int i = 0; i < DEPTH; i++) begin
         set_issue(OPC_OP, RW'(i), 32'd0, 32'd0, 1'b1, RW'(16 + i), 1'b0, 5'd0);
         tick();
      end
      set_issue(OPC_OP, 5'd30, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
      chk("full_ready", issue_ready, 0);
      chk("full_occ", occupancy, DEPTH);
      set_cdb(0, 5'd18, 32'h1234);
      tick();
      cdb_valid = '0;
      chk("full_wake_ready", issue_ready, 0);
      tick();
      chk("full_free_ready", issue_ready, 1);
      chk("full_free_occ", occupancy, DEPTH - 1);
      chk("full_disp_rob", exec_rob_id, 2);
      chk("full_disp_vj", exec_vj, 32'h1234);
      idle();
      flush_pipeline = 1'b1;
      tick();
      idle();

      // Back-pressure with two ready entries.
      exec_ready = 1'b0;
      set_issue(OPC_OP, 5'd10, 32'd1, 32'd2, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
      set_issue(OPC_OP, 5'd11, 32'd3, 32'd4, 1'b0, 5'd0, 1'b0, 5'd0);
      tick();
      idle();
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("stall_rob", exec_rob_id, 10);
         chk("stall_vj", exec_vj, 1);
      end
      exec_ready = 1'b1;
      tick();
      chk("release_rob", exec_rob_id, 11);
      tick();
      chk("drain_valid", exec_valid, 0);

      // Flush beats simultaneous issue and wake-up; paused flush is ignored.
      for (int i = 0; i < 3; i++) begin
         set_issue(OPC_OP, RW'(i), 32'd0, 32'd0, 1'b1, RW'(25 + i), 1'b0, 5'd0);
         tick();
      end
      set_issue(OPC_OP, 5'd20, 32'd1, 32'd1, 1'b0, 5'd0, 1'b0, 5'd0);
      set_cdb(0, 5'd25, 32'h77);
      flush_pipeline = 1'b1;
      tick();
      chk("flush_occ", occupancy, 0);
      chk("flush_valid", exec_valid, 0);
      idle();
      for (int i = 0; i < 3; i++) begin
         set_issue(OPC_OP, RW'(i), 32'd0, 32'd0, 1'b1, RW'(25 + i), 1'b0, 5'd0);
         tick();
      end
      rdy_in = 1'b0;
      flush_pipeline = 1'b1;
      set_cdb(0, 5'd25, 32'h77);
      tick();
      tick();
      chk("pause_occ", occupancy, 3);
      idle();
      flush_pipeline = 1'b1;
      tick();
      idle();

      for (int n = 0; n < 3000; n++) begin
         rand_inputs();
         tick();
      end

      // Asynchronous reset with three busy entries.
      idle();
      exec_ready = 1'b1;
      flush_pipeline = 1'b1;
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         set_issue(OPC_OP, RW'(i), 32'd0, 32'd0, 1'b1, RW'(29 + i), 1'b0, 5'd0);
         tick();
      end
      idle();
      chk("pre_rst_occ", occupancy, 3);
      #2 rst_in = 1'b1;
      model_reset();
      #1;
      chk("mid_rst_occ", occupancy, 0);
      chk("mid_rst_valid", exec_valid, 0);
      chk("mid_rst_ready", issue_ready, 1);
      #3 rst_in = 1'b0;
      for (int n = 0; n < 200; n++) begin
         rand_inputs();
         tick();
      end
      idle();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
